// File: rtl/dcache_wb_buf.sv
// Write-back victim buffer: queues dirty D-cache evictions, drains them over a
// req/ack bus one at a time, and lets the MSHR look up blocks still in flight.
module dcache_wb_buf #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8,
    parameter int IDX_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       evict_en_i,
    input  logic [TAG_W-1:0]           evict_tag_i,
    input  logic [IDX_W-1:0]           evict_idx_i,
    input  logic [63:0]                evict_data_i,
    output logic                       evict_rdy_o,
    output logic                       wb_req_o,
    output logic [63:0]                wb_addr_o,
    output logic [63:0]                wb_data_o,
    input  logic                       wb_ack_i,
    input  logic [TAG_W-1:0]           lkup_tag_i,
    input  logic [IDX_W-1:0]           lkup_idx_i,
    output logic                       lkup_hit_o,
    output logic [63:0]                lkup_data_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic                       ovf_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_REQ,
        ST_HOLD
    } state_e;

    logic             vld_q  [DEPTH];
    logic             vld_d  [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [TAG_W-1:0] tag_d  [DEPTH];
    logic [IDX_W-1:0] idx_q  [DEPTH];
    logic [IDX_W-1:0] idx_d  [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [63:0]      data_d [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q, state_d;
    logic          wb_req_q, wb_req_d;
    logic          ovf_q, ovf_d;

    logic          pop;
    logic          push;
    logic          merge_hit;
    logic [PW-1:0] merge_idx;
    logic          do_alloc;
    logic          do_merge;

    assign evict_rdy_o = (cnt_q != CW'(DEPTH));
    assign pop         = (state_q == ST_REQ) && wb_ack_i;
    assign push        = evict_en_i && evict_rdy_o;

    // The head being acked this cycle is leaving, so it must not absorb a merge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && tag_q[i] == evict_tag_i && idx_q[i] == evict_idx_i &&
                !(pop && PW'(i) == head_q)) begin
                merge_hit = 1'b1;
                merge_idx = PW'(i);
            end
        end
    end

    assign do_alloc = push && !merge_hit;
    assign do_merge = push && merge_hit;

    always_comb begin
        vld_d  = vld_q;
        tag_d  = tag_q;
        idx_d  = idx_q;
        data_d = data_q;
        head_d = head_q;
        tail_d = tail_q;
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        if (do_merge) begin
            data_d[merge_idx] = evict_data_i;
        end
        if (do_alloc) begin
            vld_d[tail_q]  = 1'b1;
            tag_d[tail_q]  = evict_tag_i;
            idx_d[tail_q]  = evict_idx_i;
            data_d[tail_q] = evict_data_i;
            tail_d         = tail_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(do_alloc) - CW'(pop);
        ovf_d = ovf_q | (evict_en_i & ~evict_rdy_o);
    end

    // Hold a one-cycle bubble when the last entry retires while a new one lands,
    // so two same-address blocks never appear as one continuous request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (do_alloc) state_d = ST_REQ;
            ST_REQ: begin
                if (pop) begin
                    if (cnt_q == CW'(1) && do_alloc) state_d = ST_HOLD;
                    else if (cnt_d != '0)            state_d = ST_REQ;
                    else                             state_d = ST_EMPTY;
                end
            end
            ST_HOLD:  state_d = ST_REQ;
            default:  state_d = ST_EMPTY;
        endcase
        wb_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) vld_q[i] <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            state_q  <= ST_EMPTY;
            wb_req_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            wb_req_q <= wb_req_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: payload storage is not reset; vld gating makes stale contents unobservable.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        idx_q  <= idx_d;
        data_q <= data_d;
    end

    always_comb begin
        logic [PW-1:0] slot;
        slot        = '0;
        lkup_hit_o  = 1'b0;
        lkup_data_o = '0;
        // Walk oldest to youngest so a later match overrides an earlier one.
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q + PW'(k);
            if (vld_q[slot] && tag_q[slot] == lkup_tag_i && idx_q[slot] == lkup_idx_i) begin
                lkup_hit_o  = 1'b1;
                lkup_data_o = data_q[slot];
            end
        end
    end

    assign wb_req_o  = wb_req_q;
    assign wb_addr_o = wb_req_q ? 64'({tag_q[head_q], idx_q[head_q], 3'b000}) : '0;
    assign wb_data_o = wb_req_q ? data_q[head_q] : '0;
    assign cnt_o     = cnt_q;
    assign ovf_err_o = ovf_q;

endmodule

// File: tb/tb_dcache_wb_buf.sv
// Directed bench for dcache_wb_buf: a cycle-by-cycle vector table followed by
// hand-written sequences for the drain bubble, lookup retirement and reset.
module tb_dcache_wb_buf;

    logic        clk;
    logic        rst;
    logic        evict_en_i;
    logic [7:0]  evict_tag_i;
    logic [4:0]  evict_idx_i;
    logic [63:0] evict_data_i;
    logic        evict_rdy_o;
    logic        wb_req_o;
    logic [63:0] wb_addr_o;
    logic [63:0] wb_data_o;
    logic        wb_ack_i;
    logic [7:0]  lkup_tag_i;
    logic [4:0]  lkup_idx_i;
    logic        lkup_hit_o;
    logic [63:0] lkup_data_o;
    logic [2:0]  cnt_o;
    logic        ovf_err_o;

    int n_applied = 0;
    int n_miss    = 0;

    dcache_wb_buf #(.DEPTH(4), .TAG_W(8), .IDX_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .evict_en_i   (evict_en_i),
        .evict_tag_i  (evict_tag_i),
        .evict_idx_i  (evict_idx_i),
        .evict_data_i (evict_data_i),
        .evict_rdy_o  (evict_rdy_o),
        .wb_req_o     (wb_req_o),
        .wb_addr_o    (wb_addr_o),
        .wb_data_o    (wb_data_o),
        .wb_ack_i     (wb_ack_i),
        .lkup_tag_i   (lkup_tag_i),
        .lkup_idx_i   (lkup_idx_i),
        .lkup_hit_o   (lkup_hit_o),
        .lkup_data_o  (lkup_data_o),
        .cnt_o        (cnt_o),
        .ovf_err_o    (ovf_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [7:0]  tag;
        logic [4:0]  idx;
        logic [63:0] data;
        logic        ack;
        logic [7:0]  ltag;
        logic [4:0]  lidx;
        logic        rdy;
        logic        req;
        logic [63:0] addr;
        logic [63:0] wd;
        logic        hit;
        logic [63:0] ld;
        logic [2:0]  cnt;
        logic        ovf;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] DA = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] DC = 64'hCCCC_0000_0000_000C;

    function automatic vec_t mkv(logic en, logic [7:0] tag, logic [4:0] idx, logic [63:0] data,
                                 logic ack, logic [7:0] ltag, logic [4:0] lidx,
                                 logic rdy, logic req, logic [63:0] addr, logic [63:0] wd,
                                 logic hit, logic [63:0] ld, logic [2:0] cnt, logic ovf);
        vec_t v;
        v.en = en;   v.tag = tag; v.idx = idx; v.data = data; v.ack = ack;
        v.ltag = ltag; v.lidx = lidx;
        v.rdy = rdy; v.req = req; v.addr = addr; v.wd = wd;
        v.hit = hit; v.ld = ld; v.cnt = cnt; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string nm, input logic rdy, input logic req,
                              input logic [63:0] addr, input logic [63:0] wd,
                              input logic hit, input logic [63:0] ld,
                              input logic [2:0] cnt, input logic ovf);
        check({nm, ".rdy"},   64'(evict_rdy_o), 64'(rdy));
        check({nm, ".req"},   64'(wb_req_o),    64'(req));
        check({nm, ".addr"},  wb_addr_o,        addr);
        check({nm, ".wdata"}, wb_data_o,        wd);
        check({nm, ".hit"},   64'(lkup_hit_o),  64'(hit));
        check({nm, ".ldata"}, lkup_data_o,      ld);
        check({nm, ".cnt"},   64'(cnt_o),       64'(cnt));
        check({nm, ".ovf"},   64'(ovf_err_o),   64'(ovf));
    endtask

    task automatic set_in(input logic en, input logic [7:0] tag, input logic [4:0] idx,
                          input logic [63:0] data, input logic ack,
                          input logic [7:0] ltag, input logic [4:0] lidx);
        evict_en_i   = en;
        evict_tag_i  = tag;
        evict_idx_i  = idx;
        evict_data_i = data;
        wb_ack_i     = ack;
        lkup_tag_i   = ltag;
        lkup_idx_i   = lidx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // Single push, ack after three request cycles (address = tag<<8 | idx<<3).
        tbl[0]  = mkv(0, 8'h00, 5'h00, 64'h0, 0, 8'h00, 5'h00, 1, 0, 64'h0,    64'h0, 0, 64'h0, 3'd0, 0);
        tbl[1]  = mkv(1, 8'h12, 5'h03, D1,    0, 8'h12, 5'h03, 1, 0, 64'h0,    64'h0, 0, 64'h0, 3'd0, 0);
        tbl[2]  = mkv(0, 8'h00, 5'h00, 64'h0, 0, 8'h12, 5'h03, 1, 1, 64'h1218, D1,    1, D1,    3'd1, 0);
        tbl[3]  = mkv(0, 8'h00, 5'h00, 64'h0, 0, 8'h12, 5'h03, 1, 1, 64'h1218, D1,    1, D1,    3'd1, 0);
        tbl[4]  = mkv(0, 8'h00, 5'h00, 64'h0, 1, 8'h12, 5'h03, 1, 1, 64'h1218, D1,    1, D1,    3'd1, 0);
        tbl[5]  = mkv(0, 8'h00, 5'h00, 64'h0, 0, 8'h12, 5'h03, 1, 0, 64'h0,    64'h0, 0, 64'h0, 3'd0, 0);
        // Fill to full, overflow attempt, then drain in push order.
        tbl[6]  = mkv(1, 8'h21, 5'h01, 64'h1, 0, 8'h00, 5'h00, 1, 0, 64'h0,    64'h0, 0, 64'h0, 3'd0, 0);
        tbl[7]  = mkv(1, 8'h22, 5'h02, 64'h2, 0, 8'h00, 5'h00, 1, 1, 64'h2108, 64'h1, 0, 64'h0, 3'd1, 0);
        tbl[8]  = mkv(1, 8'h23, 5'h03, 64'h3, 0, 8'h00, 5'h00, 1, 1, 64'h2108, 64'h1, 0, 64'h0, 3'd2, 0);
        tbl[9]  = mkv(1, 8'h24, 5'h04, 64'h4, 0, 8'h00, 5'h00, 1, 1, 64'h2108, 64'h1, 0, 64'h0, 3'd3, 0);
        tbl[10] = mkv(1, 8'h25, 5'h05, 64'h5, 0, 8'h00, 5'h00, 0, 1, 64'h2108, 64'h1, 0, 64'h0, 3'd4, 0);
        tbl[11] = mkv(0, 8'h00, 5'h00, 64'h0, 0, 8'h25, 5'h05, 0, 1, 64'h2108, 64'h1, 0, 64'h0, 3'd4, 1);
        tbl[12] = mkv(0, 8'h00, 5'h00, 64'h0, 1, 8'h00, 5'h00, 0, 1, 64'h2108, 64'h1, 0, 64'h0, 3'd4, 1);
        tbl[13] = mkv(0, 8'h00, 5'h00, 64'h0, 1, 8'h00, 5'h00, 1, 1, 64'h2210, 64'h2, 0, 64'h0, 3'd3, 1);
        tbl[14] = mkv(0, 8'h00, 5'h00, 64'h0, 1, 8'h00, 5'h00, 1, 1, 64'h2318, 64'h3, 0, 64'h0, 3'd2, 1);
        tbl[15] = mkv(0, 8'h00, 5'h00, 64'h0, 1, 8'h00, 5'h00, 1, 1, 64'h2420, 64'h4, 0, 64'h0, 3'd1, 1);
        tbl[16] = mkv(0, 8'h00, 5'h00, 64'h0, 0, 8'h00, 5'h00, 1, 0, 64'h0,    64'h0, 0, 64'h0, 3'd0, 1);
        // Merge of a repeated victim into the (unacked) head entry.
        tbl[17] = mkv(1, 8'h05, 5'h01, DA,    0, 8'h00, 5'h00, 1, 0, 64'h0,    64'h0, 0, 64'h0, 3'd0, 1);
        tbl[18] = mkv(1, 8'h07, 5'h02, 64'h7777, 0, 8'h00, 5'h00, 1, 1, 64'h0508, DA, 0, 64'h0, 3'd1, 1);
        tbl[19] = mkv(1, 8'h05, 5'h01, DB,    0, 8'h05, 5'h01, 1, 1, 64'h0508, DA,    1, DA,    3'd2, 1);
        tbl[20] = mkv(0, 8'h00, 5'h00, 64'h0, 0, 8'h05, 5'h01, 1, 1, 64'h0508, DB,    1, DB,    3'd2, 1);
        tbl[21] = mkv(0, 8'h00, 5'h00, 64'h0, 1, 8'h05, 5'h01, 1, 1, 64'h0508, DB,    1, DB,    3'd2, 1);
        tbl[22] = mkv(0, 8'h00, 5'h00, 64'h0, 1, 8'h05, 5'h01, 1, 1, 64'h0710, 64'h7777, 0, 64'h0, 3'd1, 1);
        tbl[23] = mkv(0, 8'h00, 5'h00, 64'h0, 0, 8'h00, 5'h00, 1, 0, 64'h0,    64'h0, 0, 64'h0, 3'd0, 1);

        rst = 1'b1;
        set_in(0, 8'h00, 5'h00, 64'h0, 0, 8'h00, 5'h00);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            set_in(tbl[i].en, tbl[i].tag, tbl[i].idx, tbl[i].data, tbl[i].ack, tbl[i].ltag, tbl[i].lidx);
            sample();
            expect_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].req, tbl[i].addr, tbl[i].wd,
                       tbl[i].hit, tbl[i].ld, tbl[i].cnt, tbl[i].ovf);
            tick();
        end

        // Reset clears the sticky overflow flag.
        rst = 1'b1;
        set_in(0, 8'h00, 5'h00, 64'h0, 0, 8'h00, 5'h00);
        tick();
        rst = 1'b0;
        sample();
        expect_out("rst1", 1, 0, 64'h0, 64'h0, 0, 64'h0, 3'd0, 0);

        // Last entry acked while a same-address victim arrives: allocate, one-cycle bubble.
        set_in(1, 8'h05, 5'h01, DA, 0, 8'h00, 5'h00);
        tick();
        set_in(1, 8'h05, 5'h01, DC, 1, 8'h05, 5'h01);
        sample();
        expect_out("hold.pre", 1, 1, 64'h0508, DA, 1, DA, 3'd1, 0);
        tick();
        set_in(0, 8'h00, 5'h00, 64'h0, 1, 8'h05, 5'h01);  // ack during the bubble is ignored
        sample();
        expect_out("hold.gap", 1, 0, 64'h0, 64'h0, 1, DC, 3'd1, 0);
        tick();
        set_in(0, 8'h00, 5'h00, 64'h0, 1, 8'h05, 5'h01);
        sample();
        expect_out("hold.req", 1, 1, 64'h0508, DC, 1, DC, 3'd1, 0);
        tick();
        set_in(0, 8'h00, 5'h00, 64'h0, 0, 8'h05, 5'h01);
        sample();
        expect_out("hold.done", 1, 0, 64'h0, 64'h0, 0, 64'h0, 3'd0, 0);
        tick();

        // Lookup distinguishes idx, and a popped entry vanishes from lookup next cycle.
        set_in(1, 8'h09, 5'h04, 64'h94, 0, 8'h00, 5'h00);
        tick();
        set_in(1, 8'h09, 5'h05, 64'h95, 0, 8'h09, 5'h04);
        sample();
        expect_out("lk.one", 1, 1, 64'h0920, 64'h94, 1, 64'h94, 3'd1, 0);
        tick();
        set_in(0, 8'h00, 5'h00, 64'h0, 1, 8'h09, 5'h04);
        sample();
        expect_out("lk.two", 1, 1, 64'h0920, 64'h94, 1, 64'h94, 3'd2, 0);
        tick();
        set_in(0, 8'h00, 5'h00, 64'h0, 0, 8'h09, 5'h04);
        sample();
        expect_out("lk.gone", 1, 1, 64'h0928, 64'h95, 0, 64'h0, 3'd1, 0);
        tick();
        set_in(0, 8'h00, 5'h00, 64'h0, 1, 8'h09, 5'h05);
        sample();
        expect_out("lk.second", 1, 1, 64'h0928, 64'h95, 1, 64'h95, 3'd1, 0);
        tick();
        set_in(0, 8'h00, 5'h00, 64'h0, 0, 8'h00, 5'h00);
        sample();
        expect_out("lk.empty", 1, 0, 64'h0, 64'h0, 0, 64'h0, 3'd0, 0);
        tick();

        // Reset mid-transfer discards pending entries; a following ack is ignored.
        set_in(1, 8'h31, 5'h01, 64'h31, 0, 8'h00, 5'h00);
        tick();
        set_in(1, 8'h32, 5'h02, 64'h32, 0, 8'h00, 5'h00);
        tick();
        set_in(1, 8'h33, 5'h03, 64'h33, 0, 8'h00, 5'h00);
        tick();
        set_in(0, 8'h00, 5'h00, 64'h0, 0, 8'h31, 5'h01);
        sample();
        expect_out("mid.busy", 1, 1, 64'h3108, 64'h31, 1, 64'h31, 3'd3, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(0, 8'h00, 5'h00, 64'h0, 1, 8'h31, 5'h01);
        sample();
        expect_out("mid.rst", 1, 0, 64'h0, 64'h0, 0, 64'h0, 3'd0, 0);
        tick();
        set_in(0, 8'h00, 5'h00, 64'h0, 0, 8'h31, 5'h01);
        sample();
        expect_out("mid.after", 1, 0, 64'h0, 64'h0, 0, 64'h0, 3'd0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
